// File: rtl/nmi_pkg.sv
// Shared NMI fabric definitions: bus widths, slave FSM state type and helpers.
package nmi_pkg;

  localparam int unsigned NMI_AW = 32;
  localparam int unsigned NMI_DW = 32;
  localparam int unsigned NMI_SW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} nmi_slv_state_e;

  // Any asserted byte strobe marks the request as a write.
  function automatic logic nmi_is_write(input logic [NMI_SW-1:0] wstrb);
    return |wstrb;
  endfunction

endpackage

// File: rtl/nmi_if.sv
// NMI request/response bundle between a fabric master and a memory-style slave.
interface nmi_if;
  import nmi_pkg::*;

  logic              valid;
  logic [NMI_AW-1:0] addr;
  logic [NMI_DW-1:0] wdata;
  logic [NMI_SW-1:0] wstrb;
  logic [NMI_DW-1:0] rdata;
  logic              ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);

endinterface

// File: rtl/nmi_ram_array.sv
// Word-addressed RAM with byte-enable writes and 1-cycle synchronous read.
// Storage is not reset so the block can be swapped for an SRAM macro wrapper.
module nmi_ram_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic [DW/8-1:0]          we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // rdata_o only updates on a read access and otherwise holds its last value.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i == '0) rdata_o <= mem[addr_i];
      for (int unsigned b = 0; b < DW/8; b++) begin
        if (we_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/nmi_sram_slave.sv
// NMI memory target: captures one request, performs the RAM op immediately,
// then acknowledges after WAIT_CYCLES extra cycles with a one-cycle ready pulse.
module nmi_sram_slave
  import nmi_pkg::*;
#(
  parameter logic [NMI_AW-1:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned       DEPTH       = 1024,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  nmi_if.slave  nmi
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (32'(1) << AW) != DEPTH) begin : g_bad_depth
    $error("nmi_sram_slave: DEPTH must be a power of 2 and >= 2");
  end
  if (BASE_ADDR[AW+1:0] != '0) begin : g_bad_base
    $error("nmi_sram_slave: BASE_ADDR must be aligned to DEPTH*4");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("nmi_sram_slave: WAIT_CYCLES must be 0..15");
  end

  nmi_slv_state_e    state;
  logic [3:0]        wait_cnt;
  logic              rd_hit;
  logic              resp_rd;
  logic              in_range;
  logic              ram_en;
  logic [AW-1:0]     word_idx;
  logic [NMI_DW-1:0] ram_rdata;
  logic              unused_addr;

  assign word_idx    = nmi.addr[AW+1:2];
  assign in_range    = nmi.addr[NMI_AW-1:AW+2] == BASE_ADDR[NMI_AW-1:AW+2];
  assign ram_en      = (state == IDLE) && nmi.valid && in_range;
  assign unused_addr = ^nmi.addr[1:0];

  nmi_ram_array #(
    .DEPTH (DEPTH),
    .DW    (NMI_DW)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (nmi.wstrb),
    .addr_i  (word_idx),
    .wdata_i (nmi.wdata),
    .rdata_o (ram_rdata)
  );

  // The RAM output register already holds the read word during RESP, so rdata
  // is a register-gated select of it rather than a second copy.
  assign nmi.rdata = resp_rd ? ram_rdata : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rd_hit    <= 1'b0;
      resp_rd   <= 1'b0;
      nmi.ready <= 1'b0;
    end else begin
      nmi.ready <= 1'b0;
      resp_rd   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (nmi.valid) begin
            rd_hit   <= in_range && !nmi_is_write(nmi.wstrb);
            wait_cnt <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              nmi.ready <= 1'b1;
              resp_rd   <= in_range && !nmi_is_write(nmi.wstrb);
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state     <= RESP;
            nmi.ready <= 1'b1;
            resp_rd   <= rd_hit;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
